// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter over one raster frame with zero-padded borders.
// The scan walks an (IMG_W+1) x (IMG_H+1) grid; pad steps flush the last column and row.
module sobel_stream_filter #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int PIX_W   = 8,
  parameter int COORD_W = 11,
  parameter int OUT_W   = PIX_W + 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [OUT_W-1:0]   threshold,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_pixel,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_eol,
  output logic               out_eof,
  output logic               busy,
  output logic               frame_done
);
  localparam int LB_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [COORD_W-1:0]   r_sx;
  logic [COORD_W-1:0]   r_sy;
  logic [1:0]           r_mode;
  logic [OUT_W-1:0]     r_thr;
  logic [PIX_W-1:0]     r_lb1 [IMG_W];
  logic [PIX_W-1:0]     r_lb2 [IMG_W];
  logic [PIX_W-1:0]     r_col_a [3];
  logic [PIX_W-1:0]     r_col_b [3];
  logic [PIX_W-1:0]     w_new [3];
  logic [PIX_W-1:0]     w_p [3][3];
  logic [LB_AW-1:0]     w_lb_idx;
  logic                 w_pad;
  logic                 w_col_real;
  logic                 w_out_free;
  logic                 w_run;
  logic                 w_adv;
  logic                 w_emit;
  logic                 w_last_step;
  logic                 w_eof_hs;
  logic signed [OUT_W-1:0] w_gx;
  logic signed [OUT_W-1:0] w_gy;
  logic [OUT_W-1:0]     w_ax;
  logic [OUT_W-1:0]     w_ay;
  logic [OUT_W-1:0]     w_sum;
  logic [OUT_W-1:0]     w_res;

  function automatic logic signed [OUT_W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  assign w_col_real  = (r_sx != X_LAST);
  assign w_pad       = !w_col_real || (r_sy == Y_LAST);
  assign w_out_free  = !out_valid || out_ready;
  assign w_run       = (r_state == S_RUN);
  assign w_adv       = w_run && (w_pad || in_valid) && w_out_free;
  assign in_ready    = w_run && !w_pad && w_out_free;
  assign w_emit      = (r_sx != '0) && (r_sy != '0);
  assign w_last_step = !w_col_real && (r_sy == Y_LAST);
  assign w_lb_idx    = r_sx[LB_AW-1:0];
  assign w_eof_hs    = out_valid && out_ready && out_eof;
  assign busy        = (r_state != S_IDLE);

  // Incoming window column; rows above the frame read zero so stale line-buffer data never leaks.
  always_comb begin
    w_new[0] = '0;
    w_new[1] = '0;
    w_new[2] = '0;
    if (w_col_real) begin
      w_new[0] = (r_sy >= COORD_W'(2)) ? r_lb2[w_lb_idx] : '0;
      w_new[1] = (r_sy >= COORD_W'(1)) ? r_lb1[w_lb_idx] : '0;
      w_new[2] = w_pad ? '0 : in_pixel;
    end else begin
      w_new[2] = '0;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_p[r][0] = (r_sx <= COORD_W'(1)) ? '0 : r_col_a[r];
      w_p[r][1] = r_col_b[r];
      w_p[r][2] = w_new[r];
    end
  end

  assign w_gx = (ext(w_p[0][2]) + (ext(w_p[1][2]) <<< 1) + ext(w_p[2][2]))
              - (ext(w_p[0][0]) + (ext(w_p[1][0]) <<< 1) + ext(w_p[2][0]));
  assign w_gy = (ext(w_p[2][0]) + (ext(w_p[2][1]) <<< 1) + ext(w_p[2][2]))
              - (ext(w_p[0][0]) + (ext(w_p[0][1]) <<< 1) + ext(w_p[0][2]));
  assign w_ax  = w_gx[OUT_W-1] ? OUT_W'(-w_gx) : OUT_W'(w_gx);
  assign w_ay  = w_gy[OUT_W-1] ? OUT_W'(-w_gy) : OUT_W'(w_gy);
  assign w_sum = w_ax + w_ay;

  always_comb begin
    w_res = w_sum;
    case (r_mode)
      2'd0:    w_res = w_sum;
      2'd1:    w_res = w_ax;
      2'd2:    w_res = w_ay;
      2'd3:    w_res = (w_sum >= r_thr) ? '1 : '0;
      default: w_res = w_sum;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN; else w_state_nxt = S_IDLE;
      S_RUN:   if (w_adv && w_last_step) w_state_nxt = S_DRAIN; else w_state_nxt = S_RUN;
      S_DRAIN: if (w_eof_hs) w_state_nxt = S_IDLE; else w_state_nxt = S_DRAIN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_mode <= 2'd0;
      r_thr  <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_mode <= mode;
      r_thr  <= threshold;
    end else if (w_adv) begin
      if (!w_col_real) begin
        r_sx <= '0;
        r_sy <= w_last_step ? '0 : r_sy + COORD_W'(1);
      end else begin
        r_sx <= r_sx + COORD_W'(1);
      end
    end
  end

  // Window and line buffers need no reset: every stale entry is masked before use.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_col_a <= r_col_b;
      r_col_b <= w_new;
      if (w_col_real) begin
        r_lb2[w_lb_idx] <= w_new[1];
        r_lb1[w_lb_idx] <= w_new[2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (r_state == S_DRAIN) && w_eof_hs;
      if (w_adv && w_emit) begin
        out_valid <= 1'b1;
        out_pixel <= w_res;
        out_x     <= r_sx - COORD_W'(1);
        out_y     <= r_sy - COORD_W'(1);
        out_eol   <= !w_col_real;
        out_eof   <= w_last_step;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Randomised bench for sobel_stream_filter: direct-convolution reference model with a
// per-cycle output checker, plus hand-computed literals for the documented cases.
module tb_sobel_stream_filter;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 8;
  localparam int CW = 11;
  localparam int OW = PW + 3;
  localparam int ALL_ONES = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [OW-1:0] threshold;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pixel;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_pixel;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic          out_eol;
  logic          out_eof;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  sobel_stream_filter #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .COORD_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .threshold(threshold),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_x(out_x), .out_y(out_y), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    int pix;
    int x;
    int y;
    bit eol;
    bit eof;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  int   img [H][W];
  int   got [H][W];
  res_t exp_q [$];
  int   fd_count = 0;
  int   n_out = 0;
  int   stall_cycles = 0;
  bit   stall_enable = 1'b0;
  int   stall_at = 0;
  int   ready_low_pct = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int px(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 0;
    return img[y][x];
  endfunction

  function automatic int model_val(input int x, input int y, input int m, input int thr);
    int gx, gy, ax, ay, s;
    gx = (px(x+1, y-1) + 2*px(x+1, y) + px(x+1, y+1)) - (px(x-1, y-1) + 2*px(x-1, y) + px(x-1, y+1));
    gy = (px(x-1, y+1) + 2*px(x, y+1) + px(x+1, y+1)) - (px(x-1, y-1) + 2*px(x, y-1) + px(x+1, y-1));
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    s  = ax + ay;
    case (m)
      0: return s;
      1: return ax;
      2: return ay;
      default: return (s >= thr) ? ALL_ONES : 0;
    endcase
  endfunction

  task automatic build_expected(input int m, input int thr);
    res_t e;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        e.pix = model_val(x, y, m, thr);
        e.x = x;
        e.y = y;
        e.eol = (x == W-1);
        e.eof = (x == W-1) && (y == H-1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_const(input int v);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = v;
  endtask

  task automatic fill_step();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = (x >= 2) ? 200 : 0;
  endtask

  task automatic fill_rand();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = int'($urandom_range(255));
  endtask

  task automatic clear_got();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) got[y][x] = -1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_pixel"}, out_pixel, 0);
    check({tag, "_out_x"}, out_x, 0);
    check({tag, "_out_y"}, out_y, 0);
    check({tag, "_out_eol"}, out_eol, 0);
    check({tag, "_out_eof"}, out_eof, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Starts a frame and feeds every pixel; abort_at>=0 asserts rst once that many pixels are in.
  task automatic run_frame(input int m, input int thr, input int bubble_pct,
                           input bit restart_mid, input int abort_at);
    int idx, cyc, fd0;
    bit hs;
    build_expected(m, thr);
    fd0 = fd_count;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'(m); threshold = OW'(thr);
    @(posedge clk); #1;
    start = 1'b0; mode = 2'($urandom); threshold = OW'($urandom);
    idx = 0;
    cyc = 0;
    while (idx < W*H && cyc < 1000 && !(abort_at >= 0 && idx >= abort_at)) begin
      in_valid = ($urandom_range(99) >= bubble_pct);
      in_pixel = in_valid ? PW'(img[idx / W][idx % W]) : PW'($urandom);
      start = (restart_mid && idx == 5) ? 1'b1 : 1'b0;
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (abort_at >= 0) begin
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("abort_rst");
      @(posedge clk); #1;
      exp_q.delete();
      rst = 1'b0;
    end else begin
      if (idx < W*H) check("feed_timeout", idx, W*H);
      cyc = 0;
      while (fd_count == fd0 && cyc < 1000) begin
        @(posedge clk);
        cyc++;
      end
      repeat (4) @(posedge clk);
      #1;
      check("frame_done_count", fd_count - fd0, 1);
      check("busy_after_frame", busy, 0);
      check("results_left", exp_q.size(), 0);
    end
  endtask

  // Output checker: every handshake against the model, holds, in_ready and frame_done timing.
  initial begin
    bit            prev_stall;
    bit            prev_eof_hs;
    logic [OW-1:0] prev_pix;
    logic [CW-1:0] prev_x;
    logic [CW-1:0] prev_y;
    res_t          e;
    prev_stall = 1'b0;
    prev_eof_hs = 1'b0;
    prev_pix = '0;
    prev_x = '0;
    prev_y = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_eof_hs = 1'b0;
      end else begin
        check("frame_done_timing", frame_done, int'(prev_eof_hs));
        if (frame_done) fd_count++;
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_pixel", out_pixel, prev_pix);
          check("hold_x", out_x, prev_x);
          check("hold_y", out_y, prev_y);
        end
        if (out_valid && !out_ready) begin
          stall_cycles++;
          check("in_ready_when_stalled", in_ready, 0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result_count", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("result_pixel", out_pixel, e.pix);
            check("result_x", out_x, e.x);
            check("result_y", out_y, e.y);
            check("result_eol", out_eol, int'(e.eol));
            check("result_eof", out_eof, int'(e.eof));
            if (out_x < CW'(W) && out_y < CW'(H)) got[out_y][out_x] = int'(out_pixel);
            n_out++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_eof_hs = out_valid && out_ready && out_eof;
        prev_pix = out_pixel;
        prev_x = out_x;
        prev_y = out_y;
      end
    end
  end

  // Downstream consumer: random readiness, or one five-cycle stall when requested.
  initial begin
    bit stalled;
    stalled = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!stall_enable) stalled = 1'b0;
      if (stall_enable && !stalled && n_out >= stall_at) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        repeat (4) begin
          @(posedge clk); #1;
        end
      end else begin
        out_ready = ($urandom_range(99) >= ready_low_pct);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc0;
    rst = 1'b1; start = 1'b0; mode = 2'd0; threshold = '0; in_valid = 1'b0; in_pixel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    fill_const(100);
    check("model_const_0_0", model_val(0, 0, 0, 0), 600);
    check("model_const_1_0", model_val(1, 0, 0, 0), 400);
    check("model_const_1_1", model_val(1, 1, 0, 0), 0);
    fill_step();
    check("model_step_m1_1_1", model_val(1, 1, 1, 0), 800);

    fill_const(100);
    clear_got();
    run_frame(0, 0, 0, 1'b0, -1);
    check("const_0_0", got[0][0], 600);
    check("const_1_0", got[0][1], 400);
    check("const_1_1", got[1][1], 0);
    check("const_2_1", got[1][2], 0);
    check("const_3_2", got[2][3], 600);

    fill_step();
    clear_got();
    run_frame(1, 0, 0, 1'b0, -1);
    check("step_m1_1_1", got[1][1], 800);
    check("step_m1_2_1", got[1][2], 800);
    clear_got();
    run_frame(2, 0, 0, 1'b0, -1);
    check("step_m2_1_1", got[1][1], 0);
    clear_got();
    run_frame(3, 500, 0, 1'b0, -1);
    check("step_m3_1_1", got[1][1], ALL_ONES);
    check("step_m3_0_1", got[1][0], 0);

    fill_rand();
    sc0 = stall_cycles;
    stall_at = n_out + 5;
    stall_enable = 1'b1;
    run_frame(0, 0, 0, 1'b0, -1);
    stall_enable = 1'b0;
    check("backpressure_stall_seen", int'((stall_cycles - sc0) >= 3), 1);

    ready_low_pct = 30;
    for (int f = 0; f < 4; f++) begin
      fill_rand();
      run_frame(f, int'($urandom_range(ALL_ONES)), 50, 1'b0, -1);
    end
    ready_low_pct = 0;

    fill_const(100);
    run_frame(0, 0, 0, 1'b0, 7);
    clear_got();
    run_frame(0, 0, 0, 1'b0, -1);
    check("after_abort_0_0", got[0][0], 600);
    check("after_abort_1_0", got[0][1], 400);
    check("after_abort_3_2", got[2][3], 600);

    fill_rand();
    run_frame(0, 0, 20, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
